// File: rtl/bpf_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpf_buf_pkg
// Description : Shared types and select codes for the ping/pang/pung buffer
//               arbiter and the agent-buffer mux network.
// Revision    : 1.0 - initial release
// ============================================================================
package bpf_buf_pkg;

    typedef logic [1:0] buf_id_t;

    localparam buf_id_t SEL_NONE = 2'b00;
    localparam buf_id_t SEL_PING = 2'b01;
    localparam buf_id_t SEL_PANG = 2'b10;
    localparam buf_id_t SEL_PUNG = 2'b11;

    localparam int NUM_BUFS = 3;

    typedef enum logic [2:0] {
        BUF_EMPTY    = 3'd0,
        BUF_SN       = 3'd1,
        BUF_WAIT_CPU = 3'd2,
        BUF_CPU      = 3'd3,
        BUF_WAIT_FWD = 3'd4,
        BUF_FWD      = 3'd5
    } buf_state_t;

    // Buffer index 0..2 maps onto select codes PING..PUNG.
    function automatic buf_id_t idx_to_sel(int idx);
        return buf_id_t'(idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpf_buf_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bpf_buf_arbiter_if
// Description : Agent done pulses in, buffer grants and lengths out.
//               Counter signals exist only when BPF_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bpf_buf_arbiter_if
    import bpf_buf_pkg::*;
#(
    parameter int PLEN_WIDTH = 11
);
    logic                  sn_done;
    logic [PLEN_WIDTH-1:0] sn_len;
    logic                  cpu_acc;
    logic                  cpu_rej;
    logic                  fwd_done;
    buf_id_t               sn_sel;
    buf_id_t               cpu_sel;
    buf_id_t               fwd_sel;
    logic [PLEN_WIDTH-1:0] cpu_len;
    logic [PLEN_WIDTH-1:0] fwd_len;
`ifdef BPF_ARB_STATS_EN
    logic [31:0]           acc_cnt;
    logic [31:0]           rej_cnt;
`endif

    modport master (
        output sn_done, sn_len, cpu_acc, cpu_rej, fwd_done,
        input  sn_sel, cpu_sel, fwd_sel, cpu_len, fwd_len
`ifdef BPF_ARB_STATS_EN
        , input acc_cnt, rej_cnt
`endif
    );

    modport slave (
        input  sn_done, sn_len, cpu_acc, cpu_rej, fwd_done,
        output sn_sel, cpu_sel, fwd_sel, cpu_len, fwd_len
`ifdef BPF_ARB_STATS_EN
        , output acc_cnt, rej_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/bpf_bufid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bpf_bufid_fifo
// Description : 3-entry FIFO of 2-bit buffer IDs; push and pop may coincide,
//               including push while full when the head is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module bpf_bufid_fifo
    import bpf_buf_pkg::*;
(
    input  wire     clk,
    input  wire     rst,
    input  wire     push,
    input  buf_id_t push_id,
    input  wire     pop,
    output buf_id_t head,
    output logic    empty,
    output logic    full
);
    buf_id_t    r_mem [3];
    logic [1:0] r_wr;
    logic [1:0] r_rd;
    logic [1:0] r_cnt;

    function automatic logic [1:0] ptr_inc(logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= 2'd0;
            r_rd   <= 2'd0;
            r_cnt  <= 2'd0;
            r_mem[0] <= SEL_NONE;
            r_mem[1] <= SEL_NONE;
            r_mem[2] <= SEL_NONE;
        end else begin
            if (push) begin
                r_mem[r_wr] <= push_id;
                r_wr        <= ptr_inc(r_wr);
            end
            if (pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign head  = r_mem[r_rd];
    assign empty = (r_cnt == 2'd0);
    assign full  = (r_cnt == 2'd3);

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && empty));
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpf_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bpf_buf_arbiter
// Description : Ping/pang/pung buffer ownership arbiter: snooper -> CPU ->
//               forwarder. Optional acc/rej counters under BPF_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bpf_buf_arbiter
    import bpf_buf_pkg::*;
#(
    parameter int PLEN_WIDTH = 11
) (
    input  wire              clk,
    input  wire              rst,
    bpf_buf_arbiter_if.slave bus
);
    buf_state_t            r_state     [NUM_BUFS];
    buf_state_t            w_state_nxt [NUM_BUFS];
    logic [PLEN_WIDTH-1:0] r_len       [NUM_BUFS];
    logic [PLEN_WIDTH-1:0] w_len_nxt   [NUM_BUFS];

    buf_id_t               r_sn_sel,  w_sn_sel_nxt;
    buf_id_t               r_cpu_sel, w_cpu_sel_nxt;
    buf_id_t               r_fwd_sel, w_fwd_sel_nxt;
    logic [PLEN_WIDTH-1:0] r_cpu_len, w_cpu_len_nxt;
    logic [PLEN_WIDTH-1:0] r_fwd_len, w_fwd_len_nxt;

    logic    w_sn_fin, w_cpu_acc, w_cpu_rej, w_fwd_fin;
    logic    w_sn_grant, w_cpu_grant, w_fwd_grant;
    buf_id_t w_sn_pick;
    buf_id_t w_cpu_head, w_fwd_head;
    logic    w_cpu_q_empty, w_cpu_q_full;
    logic    w_fwd_q_empty, w_fwd_q_full;
    logic [PLEN_WIDTH-1:0] w_cpu_head_len, w_fwd_head_len;

    // Done pulses only count while the agent actually holds a buffer.
    assign w_sn_fin  = bus.sn_done  && (r_sn_sel  != SEL_NONE);
    assign w_cpu_rej = bus.cpu_rej  && (r_cpu_sel != SEL_NONE);
    assign w_cpu_acc = bus.cpu_acc  && !bus.cpu_rej && (r_cpu_sel != SEL_NONE);
    assign w_fwd_fin = bus.fwd_done && (r_fwd_sel != SEL_NONE);

    // Grants look at pre-edge state, so a buffer freed this edge waits one cycle.
    always_comb begin
        w_sn_pick = SEL_NONE;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (r_state[i] == BUF_EMPTY) begin
                w_sn_pick = idx_to_sel(i);
            end
        end
    end

    assign w_sn_grant  = (r_sn_sel  == SEL_NONE) && (w_sn_pick != SEL_NONE);
    assign w_cpu_grant = (r_cpu_sel == SEL_NONE) && !w_cpu_q_empty;
    assign w_fwd_grant = (r_fwd_sel == SEL_NONE) && !w_fwd_q_empty;

    bpf_bufid_fifo u_cpu_q (
        .clk     (clk),
        .rst     (rst),
        .push    (w_sn_fin),
        .push_id (r_sn_sel),
        .pop     (w_cpu_grant),
        .head    (w_cpu_head),
        .empty   (w_cpu_q_empty),
        .full    (w_cpu_q_full)
    );

    bpf_bufid_fifo u_fwd_q (
        .clk     (clk),
        .rst     (rst),
        .push    (w_cpu_acc),
        .push_id (r_cpu_sel),
        .pop     (w_fwd_grant),
        .head    (w_fwd_head),
        .empty   (w_fwd_q_empty),
        .full    (w_fwd_q_full)
    );

    always_comb begin
        w_cpu_head_len = '0;
        w_fwd_head_len = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (w_cpu_head == idx_to_sel(i)) w_cpu_head_len = r_len[i];
            if (w_fwd_head == idx_to_sel(i)) w_fwd_head_len = r_len[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BUFS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_len_nxt[i]   = r_len[i];
            if (w_sn_fin && (r_sn_sel == idx_to_sel(i))) begin
                w_state_nxt[i] = BUF_WAIT_CPU;
                w_len_nxt[i]   = bus.sn_len;
            end
            if (w_cpu_acc && (r_cpu_sel == idx_to_sel(i))) w_state_nxt[i] = BUF_WAIT_FWD;
            if (w_cpu_rej && (r_cpu_sel == idx_to_sel(i))) w_state_nxt[i] = BUF_EMPTY;
            if (w_fwd_fin && (r_fwd_sel == idx_to_sel(i))) w_state_nxt[i] = BUF_EMPTY;
            if (w_sn_grant  && (w_sn_pick  == idx_to_sel(i))) w_state_nxt[i] = BUF_SN;
            if (w_cpu_grant && (w_cpu_head == idx_to_sel(i))) w_state_nxt[i] = BUF_CPU;
            if (w_fwd_grant && (w_fwd_head == idx_to_sel(i))) w_state_nxt[i] = BUF_FWD;
        end
    end

    always_comb begin
        w_sn_sel_nxt  = r_sn_sel;
        w_cpu_sel_nxt = r_cpu_sel;
        w_fwd_sel_nxt = r_fwd_sel;
        w_cpu_len_nxt = r_cpu_len;
        w_fwd_len_nxt = r_fwd_len;

        if (w_sn_fin)        w_sn_sel_nxt = SEL_NONE;
        else if (w_sn_grant) w_sn_sel_nxt = w_sn_pick;

        if (w_cpu_acc || w_cpu_rej) begin
            w_cpu_sel_nxt = SEL_NONE;
            w_cpu_len_nxt = '0;
        end else if (w_cpu_grant) begin
            w_cpu_sel_nxt = w_cpu_head;
            w_cpu_len_nxt = w_cpu_head_len;
        end

        if (w_fwd_fin) begin
            w_fwd_sel_nxt = SEL_NONE;
            w_fwd_len_nxt = '0;
        end else if (w_fwd_grant) begin
            w_fwd_sel_nxt = w_fwd_head;
            w_fwd_len_nxt = w_fwd_head_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                r_state[i] <= BUF_EMPTY;
                r_len[i]   <= '0;
            end
            r_sn_sel  <= SEL_NONE;
            r_cpu_sel <= SEL_NONE;
            r_fwd_sel <= SEL_NONE;
            r_cpu_len <= '0;
            r_fwd_len <= '0;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_len[i]   <= w_len_nxt[i];
            end
            r_sn_sel  <= w_sn_sel_nxt;
            r_cpu_sel <= w_cpu_sel_nxt;
            r_fwd_sel <= w_fwd_sel_nxt;
            r_cpu_len <= w_cpu_len_nxt;
            r_fwd_len <= w_fwd_len_nxt;
        end
    end

    assign bus.sn_sel  = r_sn_sel;
    assign bus.cpu_sel = r_cpu_sel;
    assign bus.fwd_sel = r_fwd_sel;
    assign bus.cpu_len = r_cpu_len;
    assign bus.fwd_len = r_fwd_len;

    // Three buffers bound queue occupancy; a push into a full queue is a bug.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(w_sn_fin  && w_cpu_q_full && !w_cpu_grant));
            assert (!(w_cpu_acc && w_fwd_q_full && !w_fwd_grant));
        end
    end

`ifdef BPF_ARB_STATS_EN
    logic [31:0] r_acc_cnt;
    logic [31:0] r_rej_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt <= '0;
            r_rej_cnt <= '0;
        end else begin
            if (w_cpu_acc && (r_acc_cnt != 32'hFFFF_FFFF)) r_acc_cnt <= r_acc_cnt + 32'd1;
            if (w_cpu_rej && (r_rej_cnt != 32'hFFFF_FFFF)) r_rej_cnt <= r_rej_cnt + 32'd1;
        end
    end

    assign bus.acc_cnt = r_acc_cnt;
    assign bus.rej_cnt = r_rej_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpf_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpf_buf_arbiter
// Description : Directed scoreboard bench for bpf_buf_arbiter (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpf_buf_arbiter;
    import bpf_buf_pkg::*;

    localparam int PLEN_WIDTH = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpf_buf_arbiter_if #(.PLEN_WIDTH(PLEN_WIDTH)) bus ();

    bpf_buf_arbiter #(.PLEN_WIDTH(PLEN_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    sn;
        int    cpu;
        int    fwd;
        int    clen;
        int    flen;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string tag, logic [31:0] obs, int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of pulses, queue the expected post-edge outputs, then
    // compare after the edge.
    task automatic step(string tag, bit sd, int len, bit ac, bit rj, bit fd,
                        int e_sn, int e_cpu, int e_fwd, int e_cl, int e_fl);
        exp_t e;
        e.tag = tag; e.sn = e_sn; e.cpu = e_cpu; e.fwd = e_fwd;
        e.clen = e_cl; e.flen = e_fl;
        sb.push_back(e);
        bus.sn_done  = sd;
        bus.sn_len   = PLEN_WIDTH'(len);
        bus.cpu_acc  = ac;
        bus.cpu_rej  = rj;
        bus.fwd_done = fd;
        @(posedge clk);
        #1;
        bus.sn_done  = 1'b0;
        bus.sn_len   = '0;
        bus.cpu_acc  = 1'b0;
        bus.cpu_rej  = 1'b0;
        bus.fwd_done = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".sn_sel"},  32'(bus.sn_sel),  e.sn);
            chk({e.tag, ".cpu_sel"}, 32'(bus.cpu_sel), e.cpu);
            chk({e.tag, ".fwd_sel"}, 32'(bus.fwd_sel), e.fwd);
            chk({e.tag, ".cpu_len"}, 32'(bus.cpu_len), e.clen);
            chk({e.tag, ".fwd_len"}, 32'(bus.fwd_len), e.flen);
        end
    endtask

    initial begin
        bus.sn_done = 1'b0; bus.sn_len = '0; bus.cpu_acc = 1'b0;
        bus.cpu_rej = 1'b0; bus.fwd_done = 1'b0;

        // reset 4 cycles, then first snooper grant
        rst = 1'b1;
        repeat (3) step("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_last", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("first_grant", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // fill -> CPU -> accept -> forward
        step("sn_done64",   1, 64, 0, 0, 0, 0, 0, 0, 0, 0);
        step("cpu_gets64",  0, 0,  0, 0, 0, 2, 1, 0, 64, 0);
        step("cpu_acc",     0, 0,  1, 0, 0, 2, 0, 0, 0, 0);
        step("fwd_gets64",  0, 0,  0, 0, 0, 2, 0, 1, 0, 64);
        step("fwd_done",    0, 0,  0, 0, 1, 2, 0, 0, 0, 0);
        step("idle_hold",   0, 0,  0, 0, 0, 2, 0, 0, 0, 0);

        // fill order and no-free-buffer hold
        step("fill_pang10", 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        step("cpu_pang10",  0, 0,  0, 0, 0, 1, 2, 0, 10, 0);
        step("fill_ping20", 1, 20, 0, 0, 0, 0, 2, 0, 10, 0);
        step("sn_pung",     0, 0,  0, 0, 0, 3, 2, 0, 10, 0);
        step("fill_pung30", 1, 30, 0, 0, 0, 0, 2, 0, 10, 0);
        step("all_held",    0, 0,  0, 0, 0, 0, 2, 0, 10, 0);
        step("cpu_rej",     0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
        step("order_ping",  0, 0,  0, 0, 0, 2, 1, 0, 20, 0);
        step("acc_and_rej", 0, 0,  1, 1, 0, 2, 0, 0, 0, 0);
        step("order_pung",  0, 0,  0, 0, 0, 2, 3, 0, 30, 0);

        // build up all three agents busy, then simultaneous dones
        step("acc_pung",    0, 0,  1, 0, 0, 2, 0, 0, 0, 0);
        step("fwd_pung",    0, 0,  0, 0, 0, 2, 0, 3, 0, 30);
        step("fill_pang40", 1, 40, 0, 0, 0, 0, 0, 3, 0, 30);
        step("three_busy",  0, 0,  0, 0, 0, 1, 2, 3, 40, 30);
        step("all_dones",   1, 50, 1, 0, 1, 0, 0, 0, 0, 0);
        step("all_regrant", 0, 0,  0, 0, 0, 3, 1, 2, 50, 40);
        step("fwd_done2",   0, 0,  0, 0, 1, 3, 1, 0, 50, 0);
        step("stray_fwd",   0, 0,  0, 0, 1, 3, 1, 0, 50, 0);
        step("cpu_rej2",    0, 0,  0, 1, 0, 3, 0, 0, 0, 0);
        step("stray_acc",   0, 0,  1, 0, 0, 3, 0, 0, 0, 0);
        step("stray_after", 0, 0,  0, 0, 0, 3, 0, 0, 0, 0);

`ifdef BPF_ARB_STATS_EN
        chk("acc_cnt", bus.acc_cnt, 3);
        chk("rej_cnt", bus.rej_cnt, 3);
`endif

        // occupy all three buffers, then reset mid-operation
        step("fill_pung5",  1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        step("cpu_pung5",   0, 0, 0, 0, 0, 1, 3, 0, 5, 0);
        step("fill_ping6",  1, 6, 0, 0, 0, 0, 3, 0, 5, 0);
        step("sn_pang",     0, 0, 0, 0, 0, 2, 3, 0, 5, 0);
        step("acc_pung5",   0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        step("busy3",       0, 0, 0, 0, 0, 2, 1, 3, 6, 5);
        rst = 1'b1;
        step("mid_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step("mid_rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef BPF_ARB_STATS_EN
        chk("acc_cnt_rst", bus.acc_cnt, 0);
        chk("rej_cnt_rst", bus.rej_cnt, 0);
`endif
        rst = 1'b0;
        step("regrant_ping", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("post_rst_fill", 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst_cpu",  0, 0, 0, 0, 0, 2, 1, 0, 7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
